// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Fetch FSM states, the buffered {pc,instr} entry and PC alignment helpers.
package riscv_fetch_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;

  localparam logic [PC_W-1:0] PC_ALIGN_MASK = {{(PC_W-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } if_entry_t;

  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
    return addr & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/pc_fetch_stage_if.sv
// Bundle of next-PC mux, instruction-memory and decode handshake signals.
// master = fetch stage side, slave = surrounding pipeline / memory side.
interface pc_fetch_stage_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] next_pc;
  logic            redirect;
  logic [XLEN-1:0] pc_plus4;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [31:0]     if_instr;

  modport master (
    input  next_pc, redirect, imem_gnt, imem_rvalid, imem_rdata, if_ready,
    output pc_plus4, imem_req, imem_addr, if_valid, if_pc, if_instr
  );

  modport slave (
    output next_pc, redirect, imem_gnt, imem_rvalid, imem_rdata, if_ready,
    input  pc_plus4, imem_req, imem_addr, if_valid, if_pc, if_instr
  );

endinterface

// File: rtl/fetch_buf_2e.sv
// Two-entry FIFO of fetched {pc,instr} pairs with flush; head is visible combinationally
// so a word pushed on one edge is offered to decode in the following cycle.
module fetch_buf_2e
  import riscv_fetch_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  if_entry_t push_data,
  input  logic      pop,
  input  logic      flush,
  output logic [1:0] count,
  output if_entry_t head
);

  if_entry_t  entry_reg [2];
  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] count_reg;
  logic       push_ok;
  logic       pop_ok;

  assign pop_ok  = pop && (count_reg != 2'd0);
  assign push_ok = push && ((count_reg != 2'd2) || pop_ok);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push_ok && !flush && (wr_ptr_reg == 1'(gi))) begin
          entry_reg[gi] <= push_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else if (flush) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push_ok) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop_ok)  rd_ptr_reg <= ~rd_ptr_reg;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign count = count_reg;
  assign head  = entry_reg[rd_ptr_reg];

endmodule

// File: rtl/pc_fetch_stage.sv
// Program counter plus req/gnt/rvalid fetch engine feeding a 2-entry buffer to decode.
// At most one fetch is outstanding; a redirect turns any in-flight fetch into a dropped one.
module pc_fetch_stage
  import riscv_fetch_pkg::*;
#(
  parameter int              XLEN     = PC_W,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic           clk,
  input logic           rst_n,
  pc_fetch_stage_if.master bus
);

  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] req_pc_reg;
  logic            started_reg;
  fetch_state_t    state_reg;
  fetch_state_t    state_next;

  logic [1:0]      q_count;
  if_entry_t       q_head;
  logic [XLEN-1:0] target_pc;
  logic            space;
  logic            gnt_ok;
  logic            push;
  logic            pop;

  assign target_pc = align_pc(bus.next_pc);

  // Outstanding fetch counts against capacity so its return always has a slot.
  assign space  = ({1'b0, q_count} + {2'b00, (state_reg == S_WAIT)}) < 3'd2;
  assign gnt_ok = bus.imem_req && bus.imem_gnt;
  assign push   = (state_reg == S_WAIT) && bus.imem_rvalid && !bus.redirect;
  assign pop    = bus.if_valid && bus.if_ready;

  always_comb begin
    state_next   = state_reg;
    bus.imem_req = 1'b0;
    case (state_reg)
      S_REQ: begin
        bus.imem_req = started_reg && space;
        if (gnt_ok) state_next = bus.redirect ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (bus.imem_rvalid)   state_next = S_REQ;
        else if (bus.redirect) state_next = S_DROP;
      end
      S_DROP: begin
        if (bus.imem_rvalid) state_next = S_REQ;
      end
      default: state_next = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg      <= RESET_PC;
      req_pc_reg  <= RESET_PC;
      started_reg <= 1'b0;
      state_reg   <= S_REQ;
    end else begin
      started_reg <= 1'b1;
      state_reg   <= state_next;
      if (gnt_ok) req_pc_reg <= pc_reg;
      if (bus.redirect || gnt_ok) pc_reg <= target_pc;
    end
  end

  fetch_buf_2e u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ('{pc: req_pc_reg, instr: bus.imem_rdata}),
    .pop       (pop),
    .flush     (bus.redirect),
    .count     (q_count),
    .head      (q_head)
  );

  assign bus.pc_plus4  = pc_reg + XLEN'(4);
  assign bus.imem_addr = pc_reg;
  assign bus.if_valid  = (q_count != 2'd0);
  assign bus.if_pc     = q_head.pc;
  assign bus.if_instr  = q_head.instr;

  // Memory must only return data while a fetch is in flight.
  rvalid_only_in_flight: assert property (
    @(posedge clk) disable iff (!rst_n) bus.imem_rvalid |-> (state_reg != S_REQ)
  );

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Self-checking bench: a memory responder model and a scoreboard of expected {pc,instr}
// pushed when a non-stale word returns and compared when decode pops it.
module tb_pc_fetch_stage;
  import riscv_fetch_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_fetch_stage_if #(.XLEN(32)) bus ();

  logic [31:0] redir_target;
  assign bus.next_pc = bus.redirect ? redir_target : bus.pc_plus4;

  pc_fetch_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  bit          outstanding, out_stale, rv_en, bad_data, chk_gap;
  logic [31:0] out_addr, exp_fetch;
  int          grants, cyc, last_grant;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return (a * 32'd3) ^ 32'h1357_9BDF;
  endfunction

  task automatic tick();
    bit granted, rv, popped, pushed, redir, hold_req;
    logic [31:0] hold_addr;
    exp_t e;
    bus.imem_rvalid = outstanding && rv_en;
    bus.imem_rdata  = bad_data ? 32'hDEAD_BEEF : data_of(out_addr);
    @(negedge clk);
    redir     = bus.redirect;
    rv        = bus.imem_rvalid;
    granted   = bus.imem_req && bus.imem_gnt;
    hold_req  = bus.imem_req && !bus.imem_gnt && !redir;
    hold_addr = bus.imem_addr;
    popped    = bus.if_valid && bus.if_ready;
    if (popped) begin
      if (sb.size() == 0) begin
        check_eq("if_valid_extra", 64'(bus.if_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        $display("pop  pc=%h instr=%h (exp pc=%h instr=%h)", bus.if_pc, bus.if_instr, e.pc, e.instr);
        check_eq("if_pc", 64'(bus.if_pc), 64'(e.pc));
        check_eq("if_instr", 64'(bus.if_instr), 64'(e.instr));
      end
    end
    if (granted) begin
      check_eq("imem_addr", 64'(bus.imem_addr), 64'(exp_fetch));
      grants++;
      if (chk_gap && last_grant >= 0) check_eq("grant_gap", 64'(cyc - last_grant), 64'd2);
      last_grant = cyc;
      exp_fetch  = exp_fetch + 32'd4;
    end
    pushed = 1'b0;
    if (rv) begin
      if (!out_stale && !redir) begin
        sb.push_back('{pc: out_addr, instr: bus.imem_rdata});
        pushed = 1'b1;
      end
      outstanding = 1'b0;
      bad_data    = 1'b0;
    end
    if (redir) begin
      sb.delete();
      if (outstanding) out_stale = 1'b1;
      exp_fetch = redir_target & 32'hFFFF_FFFC;
    end
    if (granted) begin
      outstanding = 1'b1;
      out_addr    = bus.imem_addr;
      out_stale   = redir;
    end
    @(posedge clk);
    #1;
    cyc++;
    bus.redirect = 1'b0;
    if (pushed) check_eq("if_valid_latency", 64'(bus.if_valid), 64'd1);
    if (redir) check_eq("flush_valid", 64'(bus.if_valid), 64'd0);
    if (hold_req) begin
      check_eq("req_hold", 64'(bus.imem_req), 64'd1);
      check_eq("addr_hold", 64'(bus.imem_addr), 64'(hold_addr));
    end
  endtask

  task automatic do_redirect(input logic [31:0] tgt);
    redir_target = tgt;
    bus.redirect = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bus.redirect = 0; bus.imem_gnt = 1; bus.imem_rvalid = 0; bus.imem_rdata = 0;
    bus.if_ready = 1; redir_target = 0;
    outstanding = 0; out_stale = 0; rv_en = 1; bad_data = 0; chk_gap = 0;
    out_addr = 0; exp_fetch = 0; grants = 0; cyc = 0; last_grant = -1;

    #12;
    check_eq("rst_imem_req", 64'(bus.imem_req), 64'd0);
    check_eq("rst_if_valid", 64'(bus.if_valid), 64'd0);
    check_eq("rst_imem_addr", 64'(bus.imem_addr), 64'h0);
    check_eq("rst_pc_plus4", 64'(bus.pc_plus4), 64'h4);
    rst_n = 1'b1;

    // Streaming: one fetch every two cycles.
    chk_gap = 1;
    repeat (12) tick();
    chk_gap = 0;
    check_eq("t1_grants", 64'(grants), 64'd6);

    // Back-pressure fills exactly two entries and stops fetching.
    bus.if_ready = 0;
    repeat (10) tick();
    check_eq("t2_sb_depth", 64'(sb.size()), 64'd2);
    check_eq("t2_if_valid", 64'(bus.if_valid), 64'd1);
    check_eq("t2_imem_req", 64'(bus.imem_req), 64'd0);
    bus.if_ready = 1;
    tick();
    bus.if_ready = 0;
    grants = 0;
    repeat (6) tick();
    check_eq("t2_one_refetch", 64'(grants), 64'd1);
    check_eq("t2_req_idle", 64'(bus.imem_req), 64'd0);
    bus.if_ready = 1;
    repeat (6) tick();

    // Redirect while waiting for data; returned word must be dropped.
    rv_en = 0;
    n = 0;
    while (!(outstanding && !out_stale) && n < 20) begin tick(); n++; end
    if (n >= 20) check_eq("t3_wait_timeout", 64'(outstanding), 64'd1);
    do_redirect(32'h100);
    rv_en = 1; bad_data = 1;
    tick();
    check_eq("t3_drop_valid", 64'(bus.if_valid), 64'd0);
    check_eq("t3_addr", 64'(bus.imem_addr), 64'h100);
    repeat (6) tick();

    // Redirect coincident with a grant.
    n = 0;
    while (!bus.imem_req && n < 20) begin tick(); n++; end
    if (n >= 20) check_eq("t4_req_timeout", 64'(bus.imem_req), 64'd1);
    do_redirect(32'h40);
    check_eq("t4_drop_req", 64'(bus.imem_req), 64'd0);
    check_eq("t4_addr", 64'(bus.imem_addr), 64'h40);
    repeat (6) tick();

    // Alignment of redirect target and PC wrap.
    do_redirect(32'h203);
    check_eq("t5_align", 64'(bus.imem_addr), 64'h200);
    repeat (4) tick();
    do_redirect(32'hFFFF_FFFC);
    check_eq("t5_wrap_plus4", 64'(bus.pc_plus4), 64'h0);
    repeat (6) tick();

    // Random grant/latency/back-pressure/redirect mix.
    for (int i = 0; i < 300; i++) begin
      bus.imem_gnt = 1'($urandom_range(0, 1));
      rv_en        = 1'($urandom_range(0, 1));
      bus.if_ready = 1'($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        redir_target = $urandom;
        bus.redirect = 1'b1;
      end
      tick();
    end
    bus.imem_gnt = 1; rv_en = 1; bus.if_ready = 1;
    repeat (10) tick();

    // Asynchronous reset mid-fetch with one entry buffered.
    bus.if_ready = 0;
    n = 0;
    while (!(sb.size() == 1 && outstanding) && n < 20) begin
      rv_en = (sb.size() == 0);
      tick();
      n++;
    end
    if (n >= 20) check_eq("t6_setup_timeout", 64'(sb.size()), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("t6_if_valid", 64'(bus.if_valid), 64'd0);
    check_eq("t6_imem_req", 64'(bus.imem_req), 64'd0);
    check_eq("t6_imem_addr", 64'(bus.imem_addr), 64'h0);
    sb.delete();
    outstanding = 0; out_stale = 0; bad_data = 0; exp_fetch = 0;
    bus.imem_rvalid = 0;
    rv_en = 1; bus.if_ready = 1;
    #2;
    rst_n = 1'b1;
    grants = 0;
    repeat (8) tick();
    check_eq("t6_grants", 64'(grants), 64'd4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
